// File: rtl/filter_test_sequencer.sv
// Stimulus/capture sequencer: streams ROM samples into a filter under test and writes aligned results to a capture RAM.
// Optional build macro FTS_CHECKSUM_EN adds a per-pass wrapping sum of captured words on checksum.
module filter_test_sequencer #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic              posClk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] filt_in,
  input  logic [RES_W-1:0]  filt_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RES_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              trig,
  output logic [RES_W-1:0]  checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  // Bit 0 tracks the word on rom_q/filt_in, bit LAT the result on filt_out.
  logic [LAT:0]      r_pipe;
  logic [LAT:0]      w_pipe_next;

  logic w_launch;
  logic w_issue;
  logic w_rd_last;
  logic w_wr_last;

  assign w_launch    = (r_state == S_IDLE) && start;
  assign w_issue     = (r_state == S_RUN);
  assign w_rd_last   = (r_rd_ptr == r_len);
  assign w_wr_last   = (r_wr_ptr == r_len);
  assign w_pipe_next = (r_pipe << 1) | (LAT+1)'(w_issue);

  // State register
  always_ff @(posedge posClk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; mode is sampled live so a continuous run ends only at a pass boundary
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_rd_last && !mode) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pipe_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    trig     = 1'b0;
    rom_addr = '0;
    case (r_state)
      S_RUN: begin
        busy     = 1'b1;
        rom_addr = r_rd_ptr;
        trig     = (r_rd_ptr == '0);
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Pointers, latched length and valid pipe
  always_ff @(posedge posClk or negedge rst) begin
    if (!rst) begin
      r_len    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_pipe   <= '0;
    end else begin
      r_pipe <= w_pipe_next;
      if (w_launch) begin
        r_len    <= len;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
        end
        if (r_pipe[LAT]) begin
          r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
        end
      end
    end
  end

  assign filt_in  = r_pipe[0] ? rom_q : '0;
  assign ram_wren = r_pipe[LAT];
  assign ram_addr = r_wr_ptr;
  assign ram_data = r_pipe[LAT] ? filt_out : '0;

`ifdef FTS_CHECKSUM_EN
  logic [RES_W-1:0] r_sum;

  // A write to index 0 opens a new pass, so the sum restarts from that word
  always_ff @(posedge posClk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_launch) begin
      r_sum <= '0;
    end else if (r_pipe[LAT]) begin
      r_sum <= (r_wr_ptr == '0) ? filt_out : r_sum + filt_out;
    end
  end

  assign checksum = r_sum;
`else
  assign checksum = '0;
`endif

endmodule
